// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, zero-register index, source encoding and popcount helper
package regfile_pkg;

    localparam int DATA_W        = 64;
    localparam int IDX_W         = 5;
    localparam int CNT_W         = IDX_W + 1;
    localparam int NUM_ARCH_REGS = 31;

    // XZR: reads as zero, never written, never tracked as pending
    localparam logic [IDX_W-1:0] ZR_IDX = IDX_W'(31);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ARCH_REGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, register-file write and hazard lookup bundle
// master: ALU/MEM requests, decode mark and read indices; observes ready, write port, hazards
// slave : the arbiter; drives ready, RegWr/RW/BusW, HazardA/B, PendingCnt
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic              AluValid;
    logic [IDX_W-1:0]  AluRW;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;
    logic              MemValid;
    logic [IDX_W-1:0]  MemRW;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;
    logic              RegWr;
    logic [IDX_W-1:0]  RW;
    logic [DATA_W-1:0] BusW;
    logic              MarkValid;
    logic [IDX_W-1:0]  MarkRW;
    logic [IDX_W-1:0]  RA;
    logic [IDX_W-1:0]  RB;
    logic              HazardA;
    logic              HazardB;
    logic [CNT_W-1:0]  PendingCnt;

    modport master (
        output AluValid, AluRW, AluData, MemValid, MemRW, MemData,
               MarkValid, MarkRW, RA, RB,
        input  AluReady, MemReady, RegWr, RW, BusW, HazardA, HazardB, PendingCnt
    );

    modport slave (
        input  AluValid, AluRW, AluData, MemValid, MemRW, MemData,
               MarkValid, MarkRW, RA, RB,
        output AluReady, MemReady, RegWr, RW, BusW, HazardA, HazardB, PendingCnt
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - pending-destination vector with set/clear, hazard lookup, popcount
// clk/rst_n: clock, async active-low reset; mark_*: set pending; clr_*: clear on register-file write
// ra/rb: decode read indices; hazard_a/b: index is pending; pending_cnt: popcount of pending
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mark_valid,
    input  logic [IDX_W-1:0] mark_rw,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_rw,
    input  logic [IDX_W-1:0] ra,
    input  logic [IDX_W-1:0] rb,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic [CNT_W-1:0] pending_cnt
);

    logic [NUM_ARCH_REGS-1:0] pending;
    logic [NUM_ARCH_REGS-1:0] pending_nxt;
    logic [2**IDX_W-1:0]      pending_ext;

    // Set is applied after clear so a newer producer marked on the write edge stays pending
    always_comb begin
        pending_nxt = pending;
        if (clr_valid && (clr_rw != ZR_IDX)) begin
            pending_nxt[clr_rw] = 1'b0;
        end
        if (mark_valid && (mark_rw != ZR_IDX)) begin
            pending_nxt[mark_rw] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= popcount(pending_nxt);
        end
    end

    // Pad to the full index space so a lookup of XZR never reads out of range
    assign pending_ext = {{(2**IDX_W - NUM_ARCH_REGS){1'b0}}, pending};
    assign hazard_a    = pending_ext[ra] && (ra != ZR_IDX);
    assign hazard_b    = pending_ext[rb] && (rb != ZR_IDX);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter of ALU/load writebacks onto the register-file write port
// Clk: rising-edge clock; ResetL: async active-low reset
// bus (slave): AluValid/AluRW/AluData/AluReady, MemValid/MemRW/MemData/MemReady,
//              RegWr/RW/BusW, MarkValid/MarkRW, RA/RB, HazardA/HazardB, PendingCnt
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic          Clk,
    input  logic          ResetL,
    regfile_wb_arbiter_if.slave bus
);

    src_e              last_grant;
    logic              alu_zr;
    logic              mem_zr;
    logic              alu_req;
    logic              mem_req;
    logic              grant_alu;
    logic              grant_mem;
    logic              reg_wr_q;
    logic [IDX_W-1:0]  rw_q;
    logic [DATA_W-1:0] busw_q;

    // XZR requests are absorbed immediately and never compete for the write port
    always_comb begin
        alu_zr    = bus.AluValid && (bus.AluRW == ZR_IDX);
        mem_zr    = bus.MemValid && (bus.MemRW == ZR_IDX);
        alu_req   = bus.AluValid && !alu_zr;
        mem_req   = bus.MemValid && !mem_zr;
        grant_alu = alu_req && (!mem_req || (last_grant == SRC_MEM));
        grant_mem = mem_req && (!alu_req || (last_grant == SRC_ALU));
    end

    assign bus.AluReady = ResetL && (alu_zr || grant_alu);
    assign bus.MemReady = ResetL && (mem_zr || grant_mem);

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            reg_wr_q   <= 1'b0;
            rw_q       <= '0;
            busw_q     <= '0;
            last_grant <= SRC_MEM;
        end else begin
            reg_wr_q <= grant_alu || grant_mem;
            if (grant_alu) begin
                rw_q       <= bus.AluRW;
                busw_q     <= bus.AluData;
                last_grant <= SRC_ALU;
            end else if (grant_mem) begin
                rw_q       <= bus.MemRW;
                busw_q     <= bus.MemData;
                last_grant <= SRC_MEM;
            end
        end
    end

    assign bus.RegWr = reg_wr_q;
    assign bus.RW    = rw_q;
    assign bus.BusW  = busw_q;

    // Clear uses the registered write so pending drops on the edge the register file captures it
    regfile_scoreboard u_scoreboard (
        .clk         (Clk),
        .rst_n       (ResetL),
        .mark_valid  (bus.MarkValid),
        .mark_rw     (bus.MarkRW),
        .clr_valid   (reg_wr_q),
        .clr_rw      (rw_q),
        .ra          (bus.RA),
        .rb          (bus.RB),
        .hazard_a    (bus.HazardA),
        .hazard_b    (bus.HazardB),
        .pending_cnt (bus.PendingCnt)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    typedef struct {
        logic [IDX_W-1:0]  rw;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic Clk = 1'b0;
    logic ResetL = 1'b0;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter dut (
        .Clk    (Clk),
        .ResetL (ResetL),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    // Write-stream scoreboard: each accepted non-XZR request must appear on the write port next cycle
    always @(negedge Clk) begin
        if (ResetL) begin
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus.RegWr !== 1'b1 || bus.RW !== e.rw || bus.BusW !== e.data) begin
                    errors++;
                    $display("FAIL wb_stream: got RegWr=%0b RW=%0d BusW=%0h expected RegWr=1 RW=%0d BusW=%0h",
                             bus.RegWr, bus.RW, bus.BusW, e.rw, e.data);
                end
            end else begin
                checks++;
                if (bus.RegWr !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got RegWr=%0b RW=%0d expected RegWr=0", bus.RegWr, bus.RW);
                end
            end
            checks++;
            if (bus.AluReady === 1'b1 && bus.MemReady === 1'b1 &&
                bus.AluRW != ZR_IDX && bus.MemRW != ZR_IDX) begin
                errors++;
                $display("FAIL double_grant: got AluReady=1 MemReady=1 expected at most one");
            end
            if (bus.AluValid && bus.AluReady === 1'b1 && bus.AluRW != ZR_IDX)
                exp_q.push_back('{bus.AluRW, bus.AluData});
            if (bus.MemValid && bus.MemReady === 1'b1 && bus.MemRW != ZR_IDX)
                exp_q.push_back('{bus.MemRW, bus.MemData});
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        ResetL = 1'b0;
        #1;
        exp_q.delete();
        ResetL = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        bus.AluValid = 1'b1;
        bus.AluRW    = 5'd3;
        #1;
        checks++; if (bus.AluReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", bus.AluReady); end
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL rst_regwr: got %0b expected 0", bus.RegWr); end
        checks++; if (bus.RW !== 5'd0 || bus.BusW !== 64'd0) begin errors++; $display("FAIL rst_rw_busw: got %0d/%0h expected 0/0", bus.RW, bus.BusW); end
        checks++; if (bus.HazardA !== 1'b0 || bus.HazardB !== 1'b0) begin errors++; $display("FAIL rst_hazard: got %0b%0b expected 00", bus.HazardA, bus.HazardB); end
        checks++; if (bus.PendingCnt !== 6'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", bus.PendingCnt); end
        bus.AluValid = 1'b0;
        step();
        ResetL = 1'b1;
    endtask

    task automatic test_single();
        bus.AluValid = 1'b1; bus.AluRW = 5'd3; bus.AluData = 64'hAA;
        @(negedge Clk);
        checks++; if (bus.AluReady !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b expected 1", bus.AluReady); end
        step();
        bus.AluValid = 1'b0;
        checks++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd3 || bus.BusW !== 64'hAA) begin
            errors++; $display("FAIL single_write: got %0b/%0d/%0h expected 1/3/aa", bus.RegWr, bus.RW, bus.BusW); end
        step();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b expected 0", bus.RegWr); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        bus.AluValid = 1'b1; bus.AluRW = 5'd1; bus.AluData = 64'h11;
        bus.MemValid = 1'b1; bus.MemRW = 5'd2; bus.MemData = 64'h22;
        @(negedge Clk);
        checks++; if (bus.AluReady !== 1'b1 || bus.MemReady !== 1'b0) begin
            errors++; $display("FAIL rr_first: got alu=%0b mem=%0b expected alu=1 mem=0", bus.AluReady, bus.MemReady); end
        step();
        bus.AluValid = 1'b0;
        @(negedge Clk);
        checks++; if (bus.MemReady !== 1'b1) begin errors++; $display("FAIL rr_second: got %0b expected 1", bus.MemReady); end
        checks++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd1 || bus.BusW !== 64'h11) begin
            errors++; $display("FAIL rr_write1: got %0b/%0d/%0h expected 1/1/11", bus.RegWr, bus.RW, bus.BusW); end
        step();
        bus.MemValid = 1'b0;
        @(negedge Clk);
        checks++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd2 || bus.BusW !== 64'h22) begin
            errors++; $display("FAIL rr_write2: got %0b/%0d/%0h expected 1/2/22", bus.RegWr, bus.RW, bus.BusW); end
        step();
    endtask

    task automatic test_zero_reg();
        bus.AluValid = 1'b1; bus.AluRW = 5'd31; bus.AluData = 64'hDEAD;
        bus.MemValid = 1'b1; bus.MemRW = 5'd5;  bus.MemData = 64'h55;
        @(negedge Clk);
        checks++; if (bus.AluReady !== 1'b1 || bus.MemReady !== 1'b1) begin
            errors++; $display("FAIL zr_both_ready: got alu=%0b mem=%0b expected 1/1", bus.AluReady, bus.MemReady); end
        step();
        bus.MemValid = 1'b0;
        checks++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd5 || bus.BusW !== 64'h55) begin
            errors++; $display("FAIL zr_write: got %0b/%0d/%0h expected 1/5/55", bus.RegWr, bus.RW, bus.BusW); end
        @(negedge Clk);
        checks++; if (bus.AluReady !== 1'b1) begin errors++; $display("FAIL zr_alone_ready: got %0b expected 1", bus.AluReady); end
        step();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL zr_no_write: got %0b expected 0", bus.RegWr); end
        bus.AluRW = 5'd6; bus.AluData = 64'h66;
        bus.MemValid = 1'b1; bus.MemRW = 5'd8; bus.MemData = 64'h88;
        @(negedge Clk);
        checks++; if (bus.AluReady !== 1'b1 || bus.MemReady !== 1'b0) begin
            errors++; $display("FAIL zr_last_grant: got alu=%0b mem=%0b expected alu=1 mem=0", bus.AluReady, bus.MemReady); end
        step();
        bus.AluValid = 1'b0;
        @(negedge Clk);
        step();
        bus.MemValid = 1'b0;
        step();
    endtask

    task automatic test_scoreboard();
        bus.MarkValid = 1'b1; bus.MarkRW = 5'd7; bus.RA = 5'd7;
        step();
        bus.MarkValid = 1'b0;
        checks++; if (bus.HazardA !== 1'b1 || bus.PendingCnt !== 6'd1) begin
            errors++; $display("FAIL sb_mark: got haz=%0b cnt=%0d expected 1/1", bus.HazardA, bus.PendingCnt); end
        bus.AluValid = 1'b1; bus.AluRW = 5'd7; bus.AluData = 64'h77;
        @(negedge Clk);
        step();
        bus.AluValid = 1'b0;
        checks++; if (bus.RegWr !== 1'b1 || bus.HazardA !== 1'b1) begin
            errors++; $display("FAIL sb_write_cycle: got wr=%0b haz=%0b expected 1/1", bus.RegWr, bus.HazardA); end
        step();
        checks++; if (bus.HazardA !== 1'b0 || bus.PendingCnt !== 6'd0) begin
            errors++; $display("FAIL sb_cleared: got haz=%0b cnt=%0d expected 0/0", bus.HazardA, bus.PendingCnt); end
    endtask

    task automatic test_same_edge();
        bus.MarkValid = 1'b1; bus.MarkRW = 5'd9; bus.RB = 5'd9;
        step();
        bus.MarkValid = 1'b0;
        bus.AluValid = 1'b1; bus.AluRW = 5'd9; bus.AluData = 64'h99;
        @(negedge Clk);
        step();
        bus.AluValid = 1'b0;
        bus.MarkValid = 1'b1; bus.MarkRW = 5'd9;
        checks++; if (bus.RegWr !== 1'b1 || bus.RW !== 5'd9) begin
            errors++; $display("FAIL se_write: got %0b/%0d expected 1/9", bus.RegWr, bus.RW); end
        step();
        bus.MarkValid = 1'b0;
        checks++; if (bus.HazardB !== 1'b1 || bus.PendingCnt !== 6'd1) begin
            errors++; $display("FAIL se_set_wins: got haz=%0b cnt=%0d expected 1/1", bus.HazardB, bus.PendingCnt); end
        bus.MarkValid = 1'b1; bus.MarkRW = 5'd31; bus.RA = 5'd31;
        step();
        bus.MarkValid = 1'b0;
        checks++; if (bus.PendingCnt !== 6'd1 || bus.HazardA !== 1'b0) begin
            errors++; $display("FAIL se_zr_mark: got cnt=%0d haz=%0b expected 1/0", bus.PendingCnt, bus.HazardA); end
    endtask

    task automatic test_reset_mid();
        bus.RA = 5'd9; bus.RB = 5'd9;
        bus.AluValid = 1'b1; bus.AluRW = 5'd12; bus.AluData = 64'hC;
        @(negedge Clk);
        checks++; if (bus.AluReady !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b expected 1", bus.AluReady); end
        step();
        bus.AluValid = 1'b0;
        checks++; if (bus.RegWr !== 1'b1 || bus.HazardA !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got wr=%0b haz=%0b expected 1/1", bus.RegWr, bus.HazardA); end
        #1;
        ResetL = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL mid_regwr: got %0b expected 0", bus.RegWr); end
        checks++; if (bus.HazardA !== 1'b0 || bus.HazardB !== 1'b0 || bus.PendingCnt !== 6'd0) begin
            errors++; $display("FAIL mid_pending: got haz=%0b%0b cnt=%0d expected 00/0", bus.HazardA, bus.HazardB, bus.PendingCnt); end
        ResetL = 1'b1;
        @(negedge Clk);
        step();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %0b expected 0", bus.RegWr); end
    endtask

    initial begin
        bus.AluValid = 1'b0; bus.AluRW = '0; bus.AluData = '0;
        bus.MemValid = 1'b0; bus.MemRW = '0; bus.MemData = '0;
        bus.MarkValid = 1'b0; bus.MarkRW = '0; bus.RA = '0; bus.RB = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_reg();
        test_scoreboard();
        test_same_edge();
        test_reset_mid();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
